// File: rtl/sipo_block_loader.sv
// sipo_block_loader
// -----------------
// Serial-in / parallel-out block assembler. Bits arrive one at a time on
// serial_in whenever WR_EN is high. Every WIDTH accepted bits form one block,
// and that block moves into a single-entry output holding register. A
// valid/ready handshake drains the holding register. If a block completes
// while the holding register is still occupied and not being drained, the
// new block is discarded and a sticky overrun flag is raised.
//
// Parameters
//   WIDTH      parallel block width in bits (2..1024)
//   MSB_FIRST  1: the first serial bit ends up in bit WIDTH-1
//              0: the first serial bit ends up in bit 0
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-high reset
//   WR_EN         accept serial_in on this edge
//   serial_in     serial data bit
//   clear         abort the partial block and clear overrun (synchronous)
//   out_ready     consumer takes parallel_out this cycle
//   parallel_out  last completed block that was delivered
//   out_valid     parallel_out holds a block not yet consumed
//   bit_count     number of bits accepted in the current partial block
//   busy          a partial block is in progress (bit_count != 0)
//   overrun       sticky: a completed block was dropped

module sipo_block_loader #(
    parameter int WIDTH     = 128,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WR_EN,
    input  logic             serial_in,
    input  logic             clear,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic [CNT_W-1:0] bit_count,
    output logic             busy,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             accept;
    logic             completing;
    logic             slot_free;

    // A bit is only taken when clear is low; clear wins and discards the
    // bit presented in the same cycle. The completing edge is the accepted
    // bit that arrives while the counter sits on the last index.
    assign accept     = WR_EN && !clear;
    assign completing = accept && (bit_count == LAST_IDX);

    // The holding register can take a new block when it is empty, or when
    // the consumer is draining it in this very cycle.
    assign slot_free  = !out_valid || out_ready;

    assign busy       = (bit_count != '0);

    // Next value of the shift register, including the bit being accepted.
    // The completed block is taken from this value so the block is
    // delivered on the same edge as its last bit, with no extra stage.
    generate
        if (MSB_FIRST) begin : g_msb_first
            always_comb begin
                shreg_next = {shreg[WIDTH-2:0], serial_in};
            end
        end else begin : g_lsb_first
            always_comb begin
                shreg_next = {serial_in, shreg[WIDTH-1:1]};
            end
        end
    endgenerate

    // Shift register and bit counter. Both hold during WR_EN gaps, and clear
    // throws away whatever partial block has built up so far. The counter
    // wraps back to zero on the completing bit, so the next accepted bit
    // starts a fresh block.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (clear) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (accept) begin
            shreg <= shreg_next;
            if (completing) begin
                bit_count <= '0;
            end else begin
                bit_count <= bit_count + CNT_W'(1);
            end
        end
    end

    // Output holding register and its valid flag. A completed block is
    // loaded only when the slot is free. Otherwise it is dropped and the
    // current contents stay put. When nothing completes, a handshake simply
    // empties the slot; parallel_out keeps its last value for inspection.
    // clear has no influence here.
    always_ff @(posedge clk) begin
        if (reset) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
        end else if (completing) begin
            if (slot_free) begin
                parallel_out <= shreg_next;
                out_valid    <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun flag. It is set whenever a completed block finds the
    // slot occupied, and it is cleared only by reset or clear. clear and a
    // completion can never coincide, because clear blocks acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (clear) begin
            overrun <= 1'b0;
        end else if (completing && !slot_free) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sipo_block_loader.sv
// tb_sipo_block_loader
// --------------------
// Drives two 8-bit loaders (MSB-first and LSB-first) from the same serial
// stream. A behavioural model tracks the expected state. Delivered blocks
// go into per-order queues and are compared when the consumer takes them.

module tb_sipo_block_loader;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset, wr_en, serial_in, clear, out_ready;

    logic [W-1:0] po_m, po_l;
    logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
    logic [2:0]   cnt_m, cnt_l;

    int checks   = 0;
    int failures = 0;

    // Scoreboard queues of blocks expected on parallel_out.
    logic [W-1:0] q_m[$];
    logic [W-1:0] q_l[$];

    // Behavioural model state.
    int           m_cnt;
    logic [W-1:0] m_acc_m, m_acc_l, m_out_m, m_out_l;
    logic         m_valid, m_ovr;

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    sipo_block_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .WR_EN(wr_en), .serial_in(serial_in),
        .clear(clear), .out_ready(out_ready), .parallel_out(po_m),
        .out_valid(valid_m), .bit_count(cnt_m), .busy(busy_m), .overrun(ovr_m)
    );

    sipo_block_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .WR_EN(wr_en), .serial_in(serial_in),
        .clear(clear), .out_ready(out_ready), .parallel_out(po_l),
        .out_valid(valid_l), .bit_count(cnt_l), .busy(busy_l), .overrun(ovr_l)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare both DUTs against the model state after an edge.
    task automatic checkModel();
        checkOutput("cnt_msb",   32'(cnt_m),   32'(m_cnt));
        checkOutput("cnt_lsb",   32'(cnt_l),   32'(m_cnt));
        checkOutput("busy_msb",  32'(busy_m),  32'(m_cnt != 0));
        checkOutput("busy_lsb",  32'(busy_l),  32'(m_cnt != 0));
        checkOutput("valid_msb", 32'(valid_m), 32'(m_valid));
        checkOutput("valid_lsb", 32'(valid_l), 32'(m_valid));
        checkOutput("ovr_msb",   32'(ovr_m),   32'(m_ovr));
        checkOutput("ovr_lsb",   32'(ovr_l),   32'(m_ovr));
        checkOutput("po_msb",    32'(po_m),    32'(m_out_m));
        checkOutput("po_lsb",    32'(po_l),    32'(m_out_l));
    endtask

    // Drive one cycle of inputs, score any handshake, update the model,
    // then sample the DUTs 1 ns after the rising edge.
    task automatic applyStimulus(input logic wr, input logic sb, input logic clr,
                                 input logic rdy, input logic rst);
        logic consume;
        logic complete;
        wr_en     = wr;
        serial_in = sb;
        clear     = clr;
        out_ready = rdy;
        reset     = rst;

        if (rst) begin
            m_cnt   = 0;
            m_acc_m = '0;
            m_acc_l = '0;
            m_out_m = '0;
            m_out_l = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            q_m.delete();
            q_l.delete();
        end else begin
            consume = m_valid && rdy;
            if (consume) begin
                checkOutput("sb_depth_msb", 32'(q_m.size()), 32'(1));
                checkOutput("sb_depth_lsb", 32'(q_l.size()), 32'(1));
                if (q_m.size() > 0) checkOutput("sb_block_msb", 32'(po_m), 32'(q_m.pop_front()));
                if (q_l.size() > 0) checkOutput("sb_block_lsb", 32'(po_l), 32'(q_l.pop_front()));
            end
            complete = 1'b0;
            if (clr) begin
                m_cnt   = 0;
                m_acc_m = '0;
                m_acc_l = '0;
                m_ovr   = 1'b0;
            end else if (wr) begin
                m_acc_m[W-1-m_cnt] = sb;
                m_acc_l[m_cnt]     = sb;
                complete = (m_cnt == W - 1);
                m_cnt = (m_cnt + 1) % W;
            end
            if (complete) begin
                if (!m_valid || rdy) begin
                    m_valid = 1'b1;
                    m_out_m = m_acc_m;
                    m_out_l = m_acc_l;
                    q_m.push_back(m_acc_m);
                    q_l.push_back(m_acc_l);
                end else begin
                    m_ovr = 1'b1;
                end
                m_acc_m = '0;
                m_acc_l = '0;
            end else if (consume) begin
                m_valid = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        checkModel();
    endtask

    // Send eight bits, first bit = seq[7]. An optional WR_EN=0 gap follows
    // each bit except the last. out_ready is held at rdy_last only on the
    // final bit's edge.
    task automatic sendByte(input logic [7:0] seq, input int gap, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, seq[7-i], 1'b0, (i == 7) ? rdy_last : 1'b0, 1'b0);
            if (i != 7) begin
                for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        m_cnt = 0; m_acc_m = '0; m_acc_l = '0; m_out_m = '0; m_out_l = '0;
        m_valid = 1'b0; m_ovr = 1'b0;
        reset = 1'b1; wr_en = 1'b0; serial_in = 1'b0; clear = 1'b0; out_ready = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_po_msb", 32'(po_m), 32'h0);
        checkOutput("reset_valid",  32'(valid_m), 32'h0);

        $display("[TB] first block, back-to-back bits");
        sendByte(8'hB2, 0, 1'b0);
        checkOutput("b2_po_msb", 32'(po_m), 32'hB2);
        checkOutput("b2_po_lsb", 32'(po_l), 32'h4D);
        checkOutput("b2_valid",  32'(valid_m), 32'h1);
        checkOutput("b2_cnt",    32'(cnt_m), 32'h0);

        $display("[TB] consume, then same block with gaps");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("drain_valid", 32'(valid_m), 32'h0);
        checkOutput("drain_hold",  32'(po_m), 32'hB2);
        sendByte(8'hB2, 2, 1'b0);
        checkOutput("gap_po_msb", 32'(po_m), 32'hB2);
        checkOutput("gap_po_lsb", 32'(po_l), 32'h4D);

        $display("[TB] overrun and clear");
        sendByte(8'hFF, 0, 1'b0);
        checkOutput("ovr_po_msb", 32'(po_m), 32'hB2);
        checkOutput("ovr_flag",   32'(ovr_m), 32'h1);
        checkOutput("ovr_valid",  32'(valid_m), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("clr_ovr",  32'(ovr_m), 32'h0);
        checkOutput("clr_hold", 32'(po_m), 32'hB2);

        $display("[TB] consume and complete on the same edge");
        sendByte(8'h0F, 0, 1'b1);
        checkOutput("sim_valid",  32'(valid_m), 32'h1);
        checkOutput("sim_po_msb", 32'(po_m), 32'h0F);
        checkOutput("sim_po_lsb", 32'(po_l), 32'hF0);
        checkOutput("sim_ovr",    32'(ovr_m), 32'h0);

        $display("[TB] reset mid-block");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_cnt", 32'(cnt_m), 32'h5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_cnt",   32'(cnt_m), 32'h0);
        checkOutput("rst_busy",  32'(busy_m), 32'h0);
        checkOutput("rst_valid", 32'(valid_m), 32'h0);
        checkOutput("rst_po",    32'(po_m), 32'h0);
        sendByte(8'h1D, 0, 1'b0);
        checkOutput("fresh_po_msb", 32'(po_m), 32'h1D);
        checkOutput("fresh_po_lsb", 32'(po_l), 32'hB8);

        $display("[TB] clear together with WR_EN");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("clrwr_cnt",  32'(cnt_m), 32'h0);
        checkOutput("clrwr_busy", 32'(busy_l), 32'h0);
        sendByte(8'h6A, 0, 1'b0);
        checkOutput("after_clr_msb", 32'(po_m), 32'h6A);
        checkOutput("after_clr_lsb", 32'(po_l), 32'h56);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
